// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I controller: FSM states,
// latched instruction class, immediate selects, ALUOp codes and trap causes.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef struct packed {
        logic alureg;
        logic aluimm;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic load;
        logic store;
        logic system;
    } class_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_LUI    = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    // A legal decode has exactly one class flag set.
    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/multicycle_control_ctrl.sv
// Combinational ALU/immediate decoder driven from the latched instruction class,
// reproducing the single-cycle control table.
module multicycle_control_ctrl
    import multicycle_control_pkg::*;
(
    input  class_t     cls,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       alu_src
);

    // Class flags are one-hot once latched, so a priority chain is sufficient.
    always_comb begin
        alu_op  = ALUOP_ADD;
        imm_src = IMM_I;
        alu_src = 1'b0;
        if (cls.alureg) begin
            alu_op  = ALUOP_FUNCT;
        end else if (cls.aluimm) begin
            alu_op  = ALUOP_FUNCT;
            alu_src = 1'b1;
        end else if (cls.load) begin
            alu_src = 1'b1;
        end else if (cls.store) begin
            imm_src = IMM_S;
            alu_src = 1'b1;
        end else if (cls.branch) begin
            alu_op  = ALUOP_BRANCH;
            imm_src = IMM_B;
        end else if (cls.jal) begin
            imm_src = IMM_J;
            alu_src = 1'b1;
        end else if (cls.jalr) begin
            alu_src = 1'b1;
        end else if (cls.lui) begin
            alu_op  = ALUOP_LUI;
            imm_src = IMM_U;
            alu_src = 1'b1;
        end else if (cls.auipc) begin
            imm_src = IMM_U;
            alu_src = 1'b1;
        end else if (cls.system) begin
            alu_op  = ALUOP_ADD;
        end else begin
            alu_op  = ALUOP_ADD;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I controller: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port with wait states, bus timeout, illegal-instruction trap and halt.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_MAX    = 255,
    parameter int HALT_ON_SYSTEM = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ALUreg,
    input  logic       ALUimm,
    input  logic       Branch,
    input  logic       JAL,
    input  logic       JALR,
    input  logic       LUI,
    input  logic       AUIPC,
    input  logic       Load,
    input  logic       Store,
    input  logic       SYSTEM,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic       BranchSig,
    output logic       Jump,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       halt,
    output logic [1:0] trap_cause
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT_MAX);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

    state_t               state_r;
    class_t               cls_r;
    class_t               cls_s;
    logic [TIMEOUT_W-1:0] wait_cnt_r;
    logic [1:0]           cause_r;
    logic                 timeout_s;
    logic                 decode_bad_s;

    logic [1:0] ctl_alu_op_s;
    logic [2:0] ctl_imm_src_s;
    logic       ctl_alu_src_s;

    logic       mem_read_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, pc_src_s;
    logic       reg_write_s, mem_to_reg_s, alu_src_s, branch_sig_s, jump_s, halt_s;
    logic [1:0] alu_op_s;
    logic [2:0] imm_src_s;

    assign cls_s = {ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM};
    assign decode_bad_s = !is_onehot(cls_s) || (cls_s.jalr && (funct3 != 3'b000));
    assign timeout_s = (TIMEOUT_MAX != 0) && (wait_cnt_r == CNT_MAX) && !mem_ready;

    multicycle_control_ctrl u_ctrl (
        .cls     (cls_r),
        .alu_op  (ctl_alu_op_s),
        .imm_src (ctl_imm_src_s),
        .alu_src (ctl_alu_src_s)
    );

    // State sequencing, wait-state counter, class latch and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            wait_cnt_r <= '0;
            cls_r      <= '0;
            cause_r    <= CAUSE_NONE;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r <= ST_DECODE;
                    end else if (timeout_s) begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_BUS;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_DECODE: begin
                    cls_r      <= cls_s;
                    wait_cnt_r <= '0;
                    if (decode_bad_s) begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_ILLEGAL;
                    end else if (cls_s.system) begin
                        if (HALT_ON_SYSTEM != 0) begin
                            state_r <= ST_HALT;
                        end else begin
                            state_r <= ST_TRAP;
                            cause_r <= CAUSE_ILLEGAL;
                        end
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wait_cnt_r <= '0;
                    if (cls_r.branch) begin
                        state_r <= ST_FETCH;
                    end else if (cls_r.load || cls_r.store) begin
                        state_r <= ST_MEM;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        wait_cnt_r <= '0;
                        state_r    <= cls_r.load ? ST_WB : ST_FETCH;
                    end else if (timeout_s) begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_BUS;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_WB: begin
                    wait_cnt_r <= '0;
                    state_r    <= ST_FETCH;
                end
                ST_HALT: state_r <= ST_HALT;
                ST_TRAP: state_r <= ST_TRAP;
                default: begin
                    state_r <= ST_TRAP;
                    cause_r <= CAUSE_ILLEGAL;
                end
            endcase
        end
    end

    // Moore decode of state and latched class; IRWrite/PCWrite/PCSrc take the live qualifiers.
    always_comb begin
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_s    = 1'b0;
        branch_sig_s = 1'b0;
        jump_s       = 1'b0;
        halt_s       = 1'b0;
        alu_op_s     = 2'b00;
        imm_src_s    = 3'b000;
        case (state_r)
            ST_FETCH: begin
                mem_read_s = 1'b1;
                ir_write_s = mem_ready;
            end
            ST_DECODE: begin
                halt_s = 1'b0;
            end
            ST_EXEC: begin
                alu_op_s  = ctl_alu_op_s;
                imm_src_s = ctl_imm_src_s;
                alu_src_s = ctl_alu_src_s;
                if (cls_r.branch) begin
                    branch_sig_s = 1'b1;
                    pc_write_s   = 1'b1;
                    pc_src_s     = branch_taken;
                end else begin
                    pc_src_s     = 1'b0;
                end
            end
            ST_MEM: begin
                adr_src_s   = 1'b1;
                mem_read_s  = cls_r.load;
                mem_write_s = cls_r.store;
                pc_write_s  = cls_r.store && mem_ready;
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                mem_to_reg_s = cls_r.load;
                jump_s       = cls_r.jal || cls_r.jalr;
                pc_src_s     = cls_r.jal || cls_r.jalr;
            end
            ST_HALT: halt_s = 1'b1;
            ST_TRAP: halt_s = 1'b1;
            default: halt_s = 1'b1;
        endcase
    end

    // Reset gates every output so an in-flight strobe drops without waiting for a clock.
    assign MemRead    = mem_read_s   && rst_n;
    assign MemWrite   = mem_write_s  && rst_n;
    assign AdrSrc     = adr_src_s    && rst_n;
    assign IRWrite    = ir_write_s   && rst_n;
    assign PCWrite    = pc_write_s   && rst_n;
    assign PCSrc      = pc_src_s     && rst_n;
    assign RegWrite   = reg_write_s  && rst_n;
    assign MemtoReg   = mem_to_reg_s && rst_n;
    assign ALUSrc     = alu_src_s    && rst_n;
    assign BranchSig  = branch_sig_s && rst_n;
    assign Jump       = jump_s       && rst_n;
    assign halt       = halt_s       && rst_n;
    assign ALUOp      = rst_n ? alu_op_s  : 2'b00;
    assign ImmSrc     = rst_n ? imm_src_s : 3'b000;
    assign trap_cause = rst_n ? cause_r   : 2'b00;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step drives inputs on the falling
// edge and checks the full output bundle against a hand-computed vector.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM;
    logic [2:0] funct3;
    logic       mem_ready, branch_taken;
    logic       MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite;
    logic       MemtoReg, ALUSrc, BranchSig, Jump, halt;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic [1:0] trap_cause;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe bit positions in the observed bundle
    localparam logic [11:0] MRD = 12'h800, MWR = 12'h400, ADR = 12'h200, IRW = 12'h100;
    localparam logic [11:0] PCW = 12'h080, PCS = 12'h040, RGW = 12'h020, M2R = 12'h010;
    localparam logic [11:0] ASR = 12'h008, BRS = 12'h004, JMP = 12'h002, HLT = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    // Class order: ALUreg ALUimm Branch JAL JALR LUI AUIPC Load Store SYSTEM
    localparam logic [9:0] C_R    = 10'b1000000000;
    localparam logic [9:0] C_I    = 10'b0100000000;
    localparam logic [9:0] C_BR   = 10'b0010000000;
    localparam logic [9:0] C_JAL  = 10'b0001000000;
    localparam logic [9:0] C_JALR = 10'b0000100000;
    localparam logic [9:0] C_LUI  = 10'b0000010000;
    localparam logic [9:0] C_LD   = 10'b0000000100;
    localparam logic [9:0] C_ST   = 10'b0000000010;
    localparam logic [9:0] C_SYS  = 10'b0000000001;
    localparam logic [9:0] C_RI   = 10'b1100000000;
    localparam logic [9:0] C_ZERO = 10'b0000000000;

    logic [18:0] obs_s;
    assign obs_s = {MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite,
                    MemtoReg, ALUSrc, BranchSig, Jump, halt, ALUOp, ImmSrc, trap_cause};

    multicycle_control #(.TIMEOUT_W(8), .TIMEOUT_MAX(4), .HALT_ON_SYSTEM(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUreg(ALUreg), .ALUimm(ALUimm), .Branch(Branch), .JAL(JAL), .JALR(JALR),
        .LUI(LUI), .AUIPC(AUIPC), .Load(Load), .Store(Store), .SYSTEM(SYSTEM),
        .funct3(funct3), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .BranchSig(BranchSig), .Jump(Jump), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .halt(halt), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] ex(input logic [11:0] s, input logic [1:0] op,
                                       input logic [2:0] imm, input logic [1:0] c);
        return {s, op, imm, c};
    endfunction

    task automatic chk(input string tag, input logic [18:0] e);
        n_checks++;
        assert (obs_s === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs_s, e);
        end
    endtask

    task automatic cyc(input logic [9:0] c, input logic [2:0] f3, input logic rdy,
                       input logic bt, input string tag, input logic [18:0] e);
        @(negedge clk);
        rst_n = 1'b1;
        {ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM} = c;
        funct3       = f3;
        mem_ready    = rdy;
        branch_taken = bt;
        #1;
        chk(tag, e);
    endtask

    task automatic rst_now(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk(tag, ex(NONE, 2'b00, 3'b000, 2'b00));
    endtask

    initial begin
        {ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM} = C_ZERO;
        funct3 = 3'b000; mem_ready = 1'b0; branch_taken = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk("reset_outputs", ex(NONE, 2'b00, 3'b000, 2'b00));

        // R-type, zero wait states
        cyc(C_R, 3'b000, 1'b1, 1'b0, "r_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_R, 3'b000, 1'b1, 1'b0, "r_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_R, 3'b000, 1'b1, 1'b0, "r_exec",   ex(NONE, 2'b10, 3'b000, 2'b00));
        cyc(C_R, 3'b000, 1'b1, 1'b0, "r_wb",     ex(RGW | PCW, 2'b00, 3'b000, 2'b00));

        // Load with three wait states in MEM
        cyc(C_LD, 3'b000, 1'b1, 1'b0, "ld_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_LD, 3'b000, 1'b1, 1'b0, "ld_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_LD, 3'b000, 1'b1, 1'b0, "ld_exec",   ex(ASR, 2'b00, 3'b000, 2'b00));
        for (int i = 0; i < 3; i++)
            cyc(C_LD, 3'b000, 1'b0, 1'b0, "ld_mem_wait", ex(MRD | ADR, 2'b00, 3'b000, 2'b00));
        cyc(C_LD, 3'b000, 1'b1, 1'b0, "ld_mem_ready", ex(MRD | ADR, 2'b00, 3'b000, 2'b00));
        cyc(C_LD, 3'b000, 1'b1, 1'b0, "ld_wb", ex(RGW | PCW | M2R, 2'b00, 3'b000, 2'b00));

        // Branch taken, then not taken
        cyc(C_BR, 3'b000, 1'b1, 1'b0, "bt_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_BR, 3'b000, 1'b1, 1'b0, "bt_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_BR, 3'b000, 1'b1, 1'b1, "bt_exec",   ex(BRS | PCW | PCS, 2'b01, 3'b010, 2'b00));
        cyc(C_BR, 3'b000, 1'b1, 1'b0, "bn_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_BR, 3'b000, 1'b1, 1'b0, "bn_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_BR, 3'b000, 1'b1, 1'b0, "bn_exec",   ex(BRS | PCW, 2'b01, 3'b010, 2'b00));

        // JAL, LUI, I-type
        cyc(C_JAL, 3'b000, 1'b1, 1'b0, "jal_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_JAL, 3'b000, 1'b1, 1'b0, "jal_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_JAL, 3'b000, 1'b1, 1'b0, "jal_exec",   ex(ASR, 2'b00, 3'b100, 2'b00));
        cyc(C_JAL, 3'b000, 1'b1, 1'b0, "jal_wb",     ex(RGW | PCW | JMP | PCS, 2'b00, 3'b000, 2'b00));
        cyc(C_LUI, 3'b000, 1'b1, 1'b0, "lui_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_LUI, 3'b000, 1'b1, 1'b0, "lui_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_LUI, 3'b000, 1'b1, 1'b0, "lui_exec",   ex(ASR, 2'b11, 3'b011, 2'b00));
        cyc(C_LUI, 3'b000, 1'b1, 1'b0, "lui_wb",     ex(RGW | PCW, 2'b00, 3'b000, 2'b00));
        cyc(C_I, 3'b000, 1'b1, 1'b0, "imm_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_I, 3'b000, 1'b1, 1'b0, "imm_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_I, 3'b000, 1'b1, 1'b0, "imm_exec",   ex(ASR, 2'b10, 3'b000, 2'b00));
        cyc(C_I, 3'b000, 1'b1, 1'b0, "imm_wb",     ex(RGW | PCW, 2'b00, 3'b000, 2'b00));

        // Store with no wait state, then legal JALR
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "st_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "st_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "st_exec",   ex(ASR, 2'b00, 3'b001, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "st_mem",    ex(MWR | ADR | PCW, 2'b00, 3'b000, 2'b00));
        cyc(C_JALR, 3'b000, 1'b1, 1'b0, "jalr_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_JALR, 3'b000, 1'b1, 1'b0, "jalr_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_JALR, 3'b000, 1'b1, 1'b0, "jalr_exec",   ex(ASR, 2'b00, 3'b000, 2'b00));
        cyc(C_JALR, 3'b000, 1'b1, 1'b0, "jalr_wb",     ex(RGW | PCW | JMP | PCS, 2'b00, 3'b000, 2'b00));

        // Store that never completes: five strobe cycles then a sticky bus trap
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "sto_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "sto_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "sto_exec",   ex(ASR, 2'b00, 3'b001, 2'b00));
        for (int i = 0; i < 5; i++)
            cyc(C_ST, 3'b000, 1'b0, 1'b0, "sto_mem_wait", ex(MWR | ADR, 2'b00, 3'b000, 2'b00));
        for (int i = 0; i < 20; i++)
            cyc(C_R, 3'b000, 1'b1, 1'b0, "sto_trap", ex(HLT, 2'b00, 3'b000, 2'b10));
        rst_now("rst_clears_bus_trap");

        // Illegal decodes and SYSTEM halt
        cyc(C_JALR, 3'b001, 1'b1, 1'b0, "jalr_bad_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_JALR, 3'b001, 1'b1, 1'b0, "jalr_bad_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_JALR, 3'b001, 1'b1, 1'b0, "jalr_bad_trap",   ex(HLT, 2'b00, 3'b000, 2'b01));
        cyc(C_R,    3'b000, 1'b1, 1'b0, "jalr_bad_stay",   ex(HLT, 2'b00, 3'b000, 2'b01));
        rst_now("rst_clears_illegal");
        cyc(C_RI, 3'b000, 1'b1, 1'b0, "multi_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_RI, 3'b000, 1'b1, 1'b0, "multi_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_RI, 3'b000, 1'b1, 1'b0, "multi_trap",   ex(HLT, 2'b00, 3'b000, 2'b01));
        rst_now("rst_after_multi");
        cyc(C_ZERO, 3'b000, 1'b1, 1'b0, "zero_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_ZERO, 3'b000, 1'b1, 1'b0, "zero_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_ZERO, 3'b000, 1'b1, 1'b0, "zero_trap",   ex(HLT, 2'b00, 3'b000, 2'b01));
        rst_now("rst_after_zero");
        cyc(C_SYS, 3'b000, 1'b1, 1'b0, "sys_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_SYS, 3'b000, 1'b1, 1'b0, "sys_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_SYS, 3'b000, 1'b1, 1'b0, "sys_halt",   ex(HLT, 2'b00, 3'b000, 2'b00));
        cyc(C_R,   3'b000, 1'b1, 1'b0, "sys_stay",   ex(HLT, 2'b00, 3'b000, 2'b00));
        rst_now("rst_after_halt");

        // Reset asserted mid-cycle while a store waits in MEM
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "str_fetch",  ex(MRD | IRW, 2'b00, 3'b000, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "str_decode", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_ST, 3'b000, 1'b1, 1'b0, "str_exec",   ex(ASR, 2'b00, 3'b001, 2'b00));
        cyc(C_ST, 3'b000, 1'b0, 1'b0, "str_mem",    ex(MWR | ADR, 2'b00, 3'b000, 2'b00));
        #2 rst_n = 1'b0;
        #1 chk("str_async_drop", ex(NONE, 2'b00, 3'b000, 2'b00));
        cyc(C_R, 3'b000, 1'b0, 1'b0, "post_reset_fetch", ex(MRD, 2'b00, 3'b000, 2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequential successor to the single-cycle `control` decoder for the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory port.
- Adds a ready handshake with wait states, bus-timeout detection, illegal-instruction detection and a sticky halt/trap state.
- Sits between the instruction decoder (one-hot class flags) and the datapath (PC, IR, regfile, ALU, memory).

Parameters:
- TIMEOUT_W, 8: width of the wait-state counter.
- TIMEOUT_MAX, 255: wait cycles allowed per memory access before a bus trap; 0 disables timeout.
- HALT_ON_SYSTEM, 1: 1 means SYSTEM class enters HALT; 0 means SYSTEM is treated as illegal (TRAP).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM  in  1 each  decoder class flags from IR, one-hot when legal
- funct3  in  3  IR[14:12]
- mem_ready  in  1  memory completes the current access this cycle
- branch_taken  in  1  ALU compare result, valid in EXEC
- MemRead, MemWrite  out  1  memory strobes
- AdrSrc  out  1  0 = PC, 1 = ALU result
- IRWrite  out  1  load IR
- PCWrite  out  1  update PC
- PCSrc  out  1  0 = PC+4, 1 = ALU target
- RegWrite  out  1  regfile write
- MemtoReg, ALUSrc, BranchSig, Jump  out  1  as in `control`
- ALUOp  out  2
- ImmSrc  out  3
- halt  out  1  sticky stop
- trap_cause  out  2  00 none, 01 illegal, 10 bus timeout

Behaviour:
- Reset:
  - Clock: clk. Reset: rst_n, asynchronous, active-low.
  - State resets to FETCH; counter, class register and trap_cause reset to 0.
  - All outputs are forced to 0 while rst_n is low.
  - The first MemRead asserts in the first clk edge period after deassertion.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. Outputs are Moore (state plus latched class), except IRWrite and PCWrite qualified by mem_ready/branch_taken as listed.
- FETCH:
  - MemRead = 1, AdrSrc = 0.
  - On mem_ready: IRWrite = 1 for that cycle, then go to DECODE.
- DECODE (1 cycle):
  - Latch the class flags.
  - Zero flags, more than one flag, or JALR with funct3 != 000 → TRAP, cause 01.
  - SYSTEM → HALT if HALT_ON_SYSTEM, else TRAP, cause 01.
  - Otherwise → EXEC.
- EXEC:
  - ALUOp, ImmSrc and ALUSrc follow the `control` table: R-type 10/000/0; I-type 10/Imm_I/1; Load, Store 00/I or S/1; Branch 01/Imm_B/0; JAL 00/Imm_J/1; JALR 00/Imm_I/1; LUI 11/Imm_U/1; AUIPC 00/Imm_U/1.
  - Branch: BranchSig = 1, PCWrite = 1, PCSrc = branch_taken, then FETCH (3 cycles total).
  - Load, Store → MEM.
  - All others → WB.
- MEM:
  - AdrSrc = 1. Load asserts MemRead; Store asserts MemWrite.
  - Strobes are held until mem_ready.
  - Load on ready → WB.
  - Store on ready: PCWrite = 1, PCSrc = 0, then FETCH.
- WB (1 cycle): RegWrite = 1, PCWrite = 1.
  - MemtoReg = Load.
  - Jump = JAL|JALR; PCSrc = Jump.
  - Then FETCH.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_ready is low.
  - When the count equals TIMEOUT_MAX and mem_ready is low → TRAP, cause 10; the strobe drops the next cycle.
  - If mem_ready arrives in the same cycle the limit is reached, ready wins.
- HALT and TRAP:
  - Absorbing until reset; all strobes are 0 and halt = 1.
  - trap_cause holds its value; HALT leaves cause at 00.
- Reset asserted mid-access immediately drops all strobes; no partial write is retried.
- Minimum cycle counts with zero wait states: R, I, LUI, AUIPC, JAL, JALR 4; Load 5; Store 4; Branch 3.

Decomposition:
- `defines.vh` holds:
  - Imm_I/S/B/U/J;
  - ALUOp codes;
  - state encoding localparams;
  - trap_cause codes.
- Natural sub-module: existing combinational `control`, instantiated to supply ALUOp, ImmSrc and ALUSrc from the latched class flags.
- The FSM, timeout counter and trap logic stay in this module.

Test Plan:
- ALUreg = 1, mem_ready tied high: FETCH, DECODE, EXEC, WB. IRWrite in cycle 1; RegWrite = 1, PCWrite = 1, PCSrc = 0 in cycle 4; next MemRead in cycle 5.
- Load with mem_ready delayed 3 cycles in MEM: MemRead, AdrSrc = 1 held 4 cycles. Then WB with RegWrite = 1, MemtoReg = 1. Total 8 cycles.
- Branch, branch_taken = 1 then a second Branch with branch_taken = 0: PCSrc = 1 then 0. PCWrite = 1 in EXEC each time; no RegWrite.
- Store with mem_ready never asserted, TIMEOUT_MAX = 4: MemWrite high 5 cycles. Then halt = 1, trap_cause = 10, MemWrite = 0; stays there for 20 cycles.
- Failing decode cases:
  - JALR with funct3 = 001 → TRAP, cause 01.
  - ALUreg = ALUimm = 1 → TRAP, cause 01.
  - SYSTEM with HALT_ON_SYSTEM = 1 → halt = 1, cause 00.
- rst_n pulled low during MEM of a Store: MemWrite drops to 0 asynchronously. After release, FETCH with MemRead = 1 and trap_cause = 00.
